// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: register offsets, bit
// positions and the bus responder state encoding.
package timer_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LOAD   = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned STATUS_EXPIRED   = 0;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is high on the last count.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/timer_controller.sv
// Memory-mapped down-counting timer with a single-cycle bus responder,
// optional auto-reload and a level interrupt.
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 32'hc0002000,
  parameter int unsigned              PRESCALE   = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rnw,
  input  logic                  i_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_irq
);

  bus_state_e            state;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window, accept;
  logic                  wr_ctrl, wr_load, wr_count, wr_status;
  logic                  tick, tick_eff, expire;
  logic                  enable, auto_reload, irq_en, expired;
  logic [DATA_WIDTH-1:0] load, count, rd_data, data_q;

  always_comb begin
    offset    = i_address - BASE_ADDR;
    in_window = (i_address >= BASE_ADDR) && (offset <= ADDR_WIDTH'(12)) &&
                (offset[1:0] == 2'b00);
    accept    = i_en && (state == BUS_IDLE) && in_window;
    wr_ctrl   = accept && !i_rnw && (offset[3:0] == OFF_CTRL);
    wr_load   = accept && !i_rnw && (offset[3:0] == OFF_LOAD);
    wr_count  = accept && !i_rnw && (offset[3:0] == OFF_COUNT);
    wr_status = accept && !i_rnw && (offset[3:0] == OFF_STATUS);
    // A COUNT write in the tick cycle overrides the tick's effect on COUNT.
    tick_eff  = tick && !wr_count;
    expire    = tick_eff && (count == '0);
  end

  always_comb begin
    rd_data = '0;
    case (offset[3:0])
      OFF_CTRL: begin
        rd_data[CTRL_ENABLE]      = enable;
        rd_data[CTRL_AUTO_RELOAD] = auto_reload;
        rd_data[CTRL_IRQ_EN]      = irq_en;
      end
      OFF_LOAD:   rd_data = load;
      OFF_COUNT:  rd_data = count;
      OFF_STATUS: rd_data[STATUS_EXPIRED] = expired;
      default:    rd_data = '0;
    endcase
  end

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (enable),
    .clr  (wr_count),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BUS_IDLE;
      data_q <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (accept) begin
            state  <= BUS_RESP;
            data_q <= i_rnw ? rd_data : '0;
          end
        end
        default: begin
          state  <= BUS_IDLE;
          data_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable      <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      load        <= '0;
      count       <= '0;
      expired     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable      <= i_data[CTRL_ENABLE];
        auto_reload <= i_data[CTRL_AUTO_RELOAD];
        irq_en      <= i_data[CTRL_IRQ_EN];
      end else if (expire && !auto_reload) begin
        enable <= 1'b0;
      end

      if (wr_load) begin
        load <= i_data;
      end

      if (wr_count) begin
        count <= i_data;
      end else if (tick_eff) begin
        if (count != '0) begin
          count <= count - DATA_WIDTH'(1);
        end else if (auto_reload) begin
          count <= load;
        end
      end

      // Expiry beats a simultaneous W1C so no event is lost.
      if (expire) begin
        expired <= 1'b1;
      end else if (wr_status && i_data[STATUS_EXPIRED]) begin
        expired <= 1'b0;
      end
    end
  end

  // Outputs are forced quiet while rst is held, including a pending response.
  assign o_busy       = (state == BUS_RESP) && !rst;
  assign o_data_valid = o_busy;
  assign o_data       = o_data_valid ? data_q : '0;
  assign o_irq        = expired && irq_en && !rst;

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller with PRESCALE=4 and directed bus traffic.
module tb_timer_controller;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] BASE = 32'hc0002000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_rnw = 1'b0;
  logic          i_en = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_busy;
  logic          o_irq;

  always #5 clk = ~clk;

  timer_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (BASE),
    .PRESCALE   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_address    (i_address),
    .i_data       (i_data),
    .i_rnw        (i_rnw),
    .i_en         (i_en),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy),
    .o_irq        (o_irq)
  );

  typedef struct {
    logic        chk;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (o_data_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_response", {31'b0, o_data_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_busy"}, {31'b0, o_busy}, 32'd1);
        if (e.chk) check({e.name, "_data"}, o_data, e.data);
      end
    end else begin
      check("idle_data_zero", o_data, 32'd0);
    end
  end

  task automatic bus_xfer(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic rnw, input logic resp, input logic [31:0] exp);
    exp_t e;
    i_address = addr;
    i_data    = data;
    i_rnw     = rnw;
    i_en      = 1'b1;
    @(posedge clk);
    #1;
    i_en     = 1'b0;
    last_acc = cyc;
    if (resp) begin
      e.chk  = rnw;
      e.data = exp;
      e.cyc  = cyc;
      e.name = name;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string name, input logic [31:0] off, input logic [31:0] data);
    bus_xfer(name, BASE + off, data, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    bus_xfer(name, BASE + off, 32'd0, 1'b1, 1'b1, exp);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic irq_at(input string name, input int target, input logic exp);
    wait_cyc(target);
    @(negedge clk);
    check(name, {31'b0, o_irq}, {31'b0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, o_data_valid}, 32'd0);
    check("rst_busy",  {31'b0, o_busy}, 32'd0);
    check("rst_irq",   {31'b0, o_irq}, 32'd0);
    check("rst_data",  o_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    rd("load_after_reset", 32'h4, 32'd0);

    // Out-of-window and misaligned accesses are ignored.
    wr("load_wr", 32'h4, 32'h12);
    bus_xfer("oob_wr",        BASE + 32'h10, 32'hff, 1'b0, 1'b0, 32'd0);
    bus_xfer("misaligned_wr", BASE + 32'h2,  32'hff, 1'b0, 1'b0, 32'd0);
    bus_xfer("misaligned_w6", BASE + 32'h6,  32'hff, 1'b0, 1'b0, 32'd0);
    bus_xfer("oob_rd",        BASE + 32'h10, 32'h0,  1'b1, 1'b0, 32'd0);
    bus_xfer("below_wr",      BASE - 32'h4,  32'hff, 1'b0, 1'b0, 32'd0);
    rd("load_kept",   32'h4, 32'h12);
    rd("ctrl_kept",   32'h0, 32'h0);
    rd("status_kept", 32'hC, 32'h0);

    // One-shot: COUNT=3, PRESCALE=4 -> expiry 16 cycles after enable.
    wr("count3", 32'h8, 32'd3);
    wr("ctrl_en", 32'h0, 32'h1);
    t = last_acc;
    wait_cyc(t + 15);
    rd("status_before_expiry", 32'hC, 32'h0);
    rd("status_expired",       32'hC, 32'h1);
    rd("ctrl_after_oneshot",   32'h0, 32'h0);
    rd("count_after_oneshot",  32'h8, 32'h0);
    wr("w1c_oneshot", 32'hC, 32'h1);
    rd("status_cleared", 32'hC, 32'h0);

    // Auto-reload with interrupt.
    wr("load2", 32'h4, 32'd2);
    wr("count0", 32'h8, 32'd0);
    wr("ctrl7", 32'h0, 32'h7);
    t = last_acc;
    irq_at("irq_low_t3", t + 3, 1'b0);
    irq_at("irq_high_t4", t + 4, 1'b1);
    wr("w1c_irq", 32'hC, 32'h1);
    irq_at("irq_dropped", t + 6, 1'b0);
    irq_at("irq_low_t15", t + 15, 1'b0);
    irq_at("irq_high_t16", t + 16, 1'b1);
    wait_cyc(t + 27);
    wr("w1c_on_expiry", 32'hC, 32'h1);
    irq_at("irq_kept_after_race", t + 29, 1'b1);
    rd("status_race", 32'hC, 32'h1);
    rd("count_reloaded", 32'h8, 32'd2);
    wr("ctrl_off", 32'h0, 32'h0);
    wr("w1c_auto", 32'hC, 32'h1);

    // CTRL write on the expiry cycle keeps enable set.
    wr("count0_b", 32'h8, 32'd0);
    wr("ctrl_en_b", 32'h0, 32'h1);
    t = last_acc;
    wait_cyc(t + 3);
    wr("ctrl_on_expiry", 32'h0, 32'h1);
    rd("ctrl_kept_enabled", 32'h0, 32'h1);
    wait_cyc(t + 9);
    rd("ctrl_cleared_later", 32'h0, 32'h0);
    rd("status_after_ctrl_race", 32'hC, 32'h1);
    wr("w1c_ctrl_race", 32'hC, 32'h1);

    // COUNT write on a tick cycle beats the decrement.
    wr("count5", 32'h8, 32'd5);
    wr("ctrl_en_c", 32'h0, 32'h1);
    t = last_acc;
    wait_cyc(t + 3);
    wr("count7_on_tick", 32'h8, 32'd7);
    rd("count_write_wins", 32'h8, 32'd7);
    wr("ctrl_off_c", 32'h0, 32'h0);

    // Reset during the response cycle suppresses the pulse and clears state.
    wr("load55", 32'h4, 32'h55);
    wr("ctrl6", 32'h0, 32'h6);
    i_address = BASE + 32'h4;
    i_rnw     = 1'b1;
    i_en      = 1'b1;
    @(posedge clk);
    #1;
    i_en = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("rst_in_resp_valid", {31'b0, o_data_valid}, 32'd0);
    check("rst_in_resp_busy",  {31'b0, o_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd("ctrl_after_rst",   32'h0, 32'h0);
    rd("load_after_rst",   32'h4, 32'h0);
    rd("count_after_rst",  32'h8, 32'h0);
    rd("status_after_rst", 32'hC, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data and counter width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'hc0002000, base of the 16-byte register window.
REQ-004 SHALL have parameter PRESCALE, default 50, clk cycles per counter tick (>=1).
REQ-005 SHALL have one clock and a synchronous active-high reset.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 i_address  in  ADDR_WIDTH  bus address from the master.
REQ-009 i_data  in  DATA_WIDTH  write data from the master.
REQ-010 i_rnw  in  1  1=read, 0=write.
REQ-011 i_en  in  1  request strobe, one cycle per transaction.
REQ-012 o_data  out  DATA_WIDTH  read data, valid only with o_data_valid.
REQ-013 o_data_valid  out  1  one-cycle response pulse (reads and writes).
REQ-014 o_busy  out  1  responder occupied; master holds i_en low while high.
REQ-015 o_irq  out  1  level interrupt = STATUS.expired & CTRL.irq_en.

Function
REQ-016 Register map (offset from BASE_ADDR): 0x0 CTRL {bit0 enable, bit1 auto_reload, bit2 irq_en}; 0x4 LOAD; 0x8 COUNT; 0xC STATUS {bit0 expired}; unused bits read 0.
REQ-017 Request accepted when i_en=1, o_busy=0 and BASE_ADDR <= i_address <= BASE_ADDR+0xC with i_address[1:0]=0; otherwise ignored, no response, no state change.
REQ-018 Bus FSM states IDLE, RESP: IDLE->RESP on accept; RESP->IDLE unconditionally next cycle.
REQ-019 o_busy=1 and o_data_valid=1 exactly in RESP; latency from accept to o_data_valid is 1 cycle.
REQ-020 Read data captured at accept cycle; o_data=0 whenever o_data_valid=0.
REQ-021 Writes take effect at the accept edge; COUNT write loads counter and clears prescaler; STATUS write clears expired where i_data[0]=1 (W1C).
REQ-022 Prescaler counts 0..PRESCALE-1 while enable=1, emitting a one-cycle tick at PRESCALE-1 then wrapping to 0; held at 0 while enable=0.
REQ-023 On tick with COUNT>0: COUNT decrements by 1.
REQ-024 On tick with COUNT=0: expired<=1; if auto_reload COUNT<=LOAD, else enable<=0 and COUNT stays 0.
REQ-025 Same-cycle expiry and STATUS W1C: set wins, expired=1.
REQ-026 Same-cycle tick and COUNT bus write: bus write wins, no decrement.
REQ-027 Same-cycle expiry clearing enable and CTRL write: CTRL write wins.
REQ-028 LOAD write does not alter COUNT.

Reset
REQ-029 On rst: FSM IDLE, CTRL=0, LOAD=0, COUNT=0, expired=0, prescaler=0, o_data=0, o_data_valid=0, o_busy=0, o_irq=0.
REQ-030 rst asserted in RESP: no response pulse issued; next cycle after rst deasserts is IDLE.

Structure
REQ-031 Register offsets, CTRL/STATUS bit positions and the bus FSM enum SHALL live in shared package timer_pkg.
REQ-032 Prescaler SHALL be sub-module timer_prescaler (inputs clk, rst, en, clr; output tick).

Verification
REQ-033 Read LOAD after reset at 0xc0002004 -> o_data_valid one cycle after accept, o_data=0, o_busy high that cycle.
REQ-034 PRESCALE=4, write COUNT=3, CTRL=0x1 -> expired set 16 cycles after enable write, enable cleared, COUNT=0.
REQ-035 LOAD=2, COUNT=0, CTRL=0x7 -> o_irq rises after 4 cycles; W1C STATUS drops o_irq; COUNT reloads to 2 and o_irq re-rises after 12 more cycles.
REQ-036 Access 0xc0002010 and 0xc0002002 -> no o_data_valid, no register change.
REQ-037 W1C STATUS landing on expiry cycle -> expired remains 1.
REQ-038 rst pulsed in RESP cycle -> o_data_valid stays 0, all registers read 0 afterward.
